spi_master_driver: RTL and testbench
====================================

// Module: spi_master_driver
// PURPOSE
//  On-chip SPI master that drives the SPI memory slave. It turns one parallel request
//  (7-bit address, R/W, 8-bit write data) into one 16-bit CS-framed transaction on sclk/cs/mosi.
//  For reads it captures the byte returned on miso. It sits directly upstream of the slave's pins.
//  Timing is slow on purpose: the slave's input conditioners see every edge only after
//  several clk cycles.
// PARAMETERS
//  HALF_PERIOD  16  clk cycles per sclk phase (low or high); must be >= 8
//  SETUP_CYCLES 16  clk cycles with cs low and sclk low before the first sclk rise
//  HOLD_CYCLES  16  clk cycles with cs low and sclk low after the last sclk fall
//  GAP_CYCLES   16  minimum clk cycles with cs high before done; sets the inter-frame gap
// PORTS
//  clk    in   1  system clock; all logic on posedge
//  reset  in   1  synchronous, active-high reset
//  start  in   1  request strobe; accepted only in IDLE
//  rw     in   1  1 = read, 0 = write; sampled with start
//  addr   in   7  memory address; sampled with start
//  wdata  in   8  write byte; sampled with start, ignored for reads
//  busy   out  1  high from the cycle after accept until done
//  done   out  1  one-cycle pulse at the end of the transaction
//  rdata  out  8  last byte read; updated only by reads
//  sclk   out  1  SPI clock, idle low
//  cs     out  1  SPI chip select, active low, idle high
//  mosi   out  1  master-out data, MSB first
//  miso   in   1  slave-out data; valid only in the data phase of a read
// BEHAVIOUR
//  Reset values: cs=1, sclk=0, mosi=0, busy=0, done=0, rdata=8'h00; state=IDLE. All outputs are registered.
//  Reset mid-transfer: the next edge forces these values. The cs rise aborts the slave, and the request is dropped.
//  Frame: byte0 = {addr[6:0], rw}; byte1 = wdata (write) or don't-care 8'h00 (read). Shift 16 bits, MSB first.
//  On accept, latch {addr,rw,wdata} into a 16-bit shift register and a bit counter = 16.
//  States and transitions:
//   IDLE:  cs=1, sclk=0. start=1 -> SETUP; latch the request; busy=1 on the next cycle.
//   SETUP: cs=0, sclk=0, mosi = bit15. After SETUP_CYCLES -> LOW.
//   LOW:   sclk=0, mosi = current MSB (held for the whole phase). After HALF_PERIOD -> HIGH.
//   HIGH:  sclk=1; the slave samples mosi on this rise.
//          Last clk cycle of HIGH, bits 7..0 of a read: shift miso into the rdata shadow register.
//          Leaving HIGH: shift the frame register left, decrement the counter.
//          Counter reaches 0 -> HOLD; otherwise -> LOW.
//   HOLD:  sclk=0, cs=0, mosi=0. After HOLD_CYCLES -> GAP.
//   GAP:   cs=1. After GAP_CYCLES -> IDLE.
//          Leaving GAP: done=1 for one cycle and busy=0 in the same cycle.
//          On a read, rdata = shadow in the same cycle.
//  Latency: done is high exactly SETUP+32*HALF+HOLD+GAP clk cycles after the accept edge (560 with defaults).
//  start while busy or while done=1: ignored, with no queueing.
//  start in the same cycle as reset: reset wins.
//  Back-to-back: start may be re-asserted in the cycle after done. cs stays high for at least GAP_CYCLES.
//  mosi changes only while sclk is low. sclk never toggles while cs=1.
//  Phase counters are $clog2(max param)+1 bits wide and reload on every state entry.
// TESTING
//  1 Reset: assert reset 3 cycles mid-frame -> cs=1, sclk=0, mosi=0, busy=0, done=0, rdata=00 on the next edge.
//  2 Write: addr=7'h05, rw=0, wdata=A5 -> mosi at the 16 sclk rises = 0x0A then 0xA5.
//    Also 16 sclk pulses, each HALF_PERIOD high; done at cycle 560; rdata unchanged.
//  3 Read: addr=7'h12, rw=1; bench miso model returns 3C MSB-first in data phase -> byte0 = 0x25, rdata=3C at done.
//  4 start pulsed at cycle 100 of an active frame -> ignored; exactly one done; frame bits unchanged.
//  5 Two back-to-back writes (start in the cycle after done) -> cs high for >= GAP_CYCLES between frames; both frames correct.
//  6 Integration with the SPI memory slave: write 8'hC3 to addr 7'h2A, then read 7'h2A -> rdata=C3.
//    Then read 7'h2B -> previously written value.

Source files
------------

// File: rtl/spi_master_driver_if.sv
// Request/response and SPI pin bundle between the master driver and its counterparts.
// The master modport is the driver's view; slave is the requester plus memory side.
interface spi_master_driver_if;
    logic       start;
    logic       rw;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic       busy;
    logic       done;
    logic [7:0] rdata;
    logic       sclk;
    logic       cs;
    logic       mosi;
    logic       miso;

    modport master (
        input  start, rw, addr, wdata, miso,
        output busy, done, rdata, sclk, cs, mosi
    );

    modport slave (
        output start, rw, addr, wdata, miso,
        input  busy, done, rdata, sclk, cs, mosi
    );
endinterface

// File: rtl/spi_master_driver.sv
// SPI master: one parallel request becomes one 16-bit cs-framed transfer, with deliberately
// slow phases so the slave's synchronising input conditioners see every edge.
module spi_master_driver #(
    parameter int unsigned HALF_PERIOD  = 16,
    parameter int unsigned SETUP_CYCLES = 16,
    parameter int unsigned HOLD_CYCLES  = 16,
    parameter int unsigned GAP_CYCLES   = 16
) (
    input logic                 clk,
    input logic                 reset,
    spi_master_driver_if.master bus
);

    localparam int unsigned MaxSh  = (SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES;
    localparam int unsigned MaxHg  = (HALF_PERIOD > GAP_CYCLES) ? HALF_PERIOD : GAP_CYCLES;
    localparam int unsigned MaxPar = (MaxSh > MaxHg) ? MaxSh : MaxHg;
    localparam int unsigned PhW    = $clog2(MaxPar) + 1;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StLow,
        StHigh,
        StHold,
        StGap
    } state_e;

    state_e           state_q, state_d;
    logic [PhW-1:0]   phase_q, phase_d;
    logic [4:0]       bit_q, bit_d;
    logic [15:0]      frame_q, frame_d;
    logic             rw_q, rw_d;
    logic [7:0]       shadow_q, shadow_d;
    logic [7:0]       rdata_q, rdata_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             sclk_q, sclk_d;
    logic             cs_q, cs_d;
    logic             mosi_q, mosi_d;
    logic             phase_last;

    // Every phase lasts (length - 1) down to zero, so the counter reloads with length - 1.
    function automatic logic [PhW-1:0] phase_load(input state_e st);
        logic [PhW-1:0] val;
        val = '0;
        case (st)
            StSetup:     val = PhW'(SETUP_CYCLES - 1);
            StLow:       val = PhW'(HALF_PERIOD - 1);
            StHigh:      val = PhW'(HALF_PERIOD - 1);
            StHold:      val = PhW'(HOLD_CYCLES - 1);
            StGap:       val = PhW'(GAP_CYCLES - 1);
            default:     val = '0;
        endcase
        return val;
    endfunction

    always_comb begin
        state_d    = state_q;
        frame_d    = frame_q;
        bit_d      = bit_q;
        rw_d       = rw_q;
        shadow_d   = shadow_q;
        rdata_d    = rdata_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        phase_last = (phase_q == '0);

        case (state_q)
            StIdle: begin
                // The done cycle still reads as IDLE; a start there is dropped.
                if (bus.start && !done_q) begin
                    state_d = StSetup;
                    frame_d = {bus.addr, bus.rw, (bus.rw ? 8'h00 : bus.wdata)};
                    rw_d    = bus.rw;
                    bit_d   = 5'd16;
                    busy_d  = 1'b1;
                end
            end
            StSetup: begin
                if (phase_last) state_d = StLow;
            end
            StLow: begin
                if (phase_last) state_d = StHigh;
            end
            StHigh: begin
                if (phase_last) begin
                    if (rw_q && (bit_q <= 5'd8)) shadow_d = {shadow_q[6:0], bus.miso};
                    frame_d = {frame_q[14:0], 1'b0};
                    bit_d   = bit_q - 5'd1;
                    state_d = (bit_q == 5'd1) ? StHold : StLow;
                end
            end
            StHold: begin
                if (phase_last) state_d = StGap;
            end
            StGap: begin
                if (phase_last) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    if (rw_q) rdata_d = shadow_q;
                end
            end
            default: state_d = StIdle;
        endcase

        if (state_d != state_q) begin
            phase_d = phase_load(state_d);
        end else if (!phase_last) begin
            phase_d = phase_q - PhW'(1);
        end else begin
            phase_d = phase_q;
        end

        // Pin values follow the next state so the registered pins line up with state_q.
        cs_d   = 1'b1;
        sclk_d = 1'b0;
        mosi_d = 1'b0;
        case (state_d)
            StSetup, StLow: begin
                cs_d   = 1'b0;
                mosi_d = frame_d[15];
            end
            StHigh: begin
                cs_d   = 1'b0;
                sclk_d = 1'b1;
                mosi_d = frame_d[15];
            end
            StHold:  cs_d = 1'b0;
            default: cs_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            phase_q  <= '0;
            bit_q    <= 5'd0;
            frame_q  <= 16'h0000;
            rw_q     <= 1'b0;
            shadow_q <= 8'h00;
            rdata_q  <= 8'h00;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            sclk_q   <= 1'b0;
            cs_q     <= 1'b1;
            mosi_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            bit_q    <= bit_d;
            frame_q  <= frame_d;
            rw_q     <= rw_d;
            shadow_q <= shadow_d;
            rdata_q  <= rdata_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            sclk_q   <= sclk_d;
            cs_q     <= cs_d;
            mosi_q   <= mosi_d;
        end
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.rdata = rdata_q;
    assign bus.sclk  = sclk_q;
    assign bus.cs    = cs_q;
    assign bus.mosi  = mosi_q;

endmodule

// File: tb/tb_spi_master_driver.sv
// Bench for spi_master_driver: table of transfers against a behavioural SPI memory slave,
// plus hand-written sequences for reset, ignored starts and back-to-back frames.
module tb_spi_master_driver;

    localparam int HP  = 16;
    localparam int SU  = 16;
    localparam int HO  = 16;
    localparam int GP  = 16;
    localparam int LAT = SU + 32 * HP + HO + GP;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    spi_master_driver_if bus();

    spi_master_driver #(
        .HALF_PERIOD (HP),
        .SETUP_CYCLES(SU),
        .HOLD_CYCLES (HO),
        .GAP_CYCLES  (GP)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Behavioural SPI memory slave and pin monitors, sampled away from the DUT edge.
    logic [7:0]  mem [128];
    logic        sclk_p = 1'b0;
    logic        cs_p   = 1'b1;
    logic        mosi_p = 1'b0;
    int          bitn   = 0;
    int          rises  = 0;
    logic [15:0] cap    = 16'h0000;
    logic [7:0]  s_dat  = 8'h00;
    logic [6:0]  s_addr = 7'h00;
    logic        s_rw   = 1'b0;
    int          hi_len = 0;
    int          bad_hi = 0;
    int          bad_idle = 0;
    int          bad_mosi = 0;
    int          cs_hi_len = 0;
    int          last_gap = 0;

    always @(negedge clk) begin
        sclk_p <= bus.sclk;
        cs_p   <= bus.cs;
        mosi_p <= bus.mosi;
        if (bus.cs === 1'b1) begin
            cs_hi_len <= cs_hi_len + 1;
            bitn      <= 0;
            bus.miso  <= 1'b0;
            if (bus.sclk === 1'b1) bad_idle <= bad_idle + 1;
        end else begin
            cs_hi_len <= 0;
            if (cs_p) begin
                last_gap <= cs_hi_len;
                rises    <= 0;
            end
            if (bus.sclk && !sclk_p) begin
                cap   <= {cap[14:0], bus.mosi};
                rises <= rises + 1;
                bitn  <= bitn + 1;
                s_dat <= {s_dat[6:0], bus.mosi};
                if (bitn == 7) begin
                    s_addr <= s_dat[6:0];
                    s_rw   <= bus.mosi;
                end
                if (bitn == 15 && !s_rw) mem[s_addr] <= {s_dat[6:0], bus.mosi};
            end
            if (!bus.sclk && sclk_p && s_rw && bitn >= 8 && bitn < 16)
                bus.miso <= mem[s_addr][15 - bitn];
        end
        if (bus.sclk === 1'b1) begin
            hi_len <= hi_len + 1;
            if (sclk_p && bus.mosi !== mosi_p) bad_mosi <= bad_mosi + 1;
        end else if (sclk_p) begin
            if (hi_len != HP) bad_hi <= bad_hi + 1;
            hi_len <= 0;
        end
    end

    // Issues one request and returns one cycle after done (or after the cycle budget).
    task automatic do_txn(input logic r, input logic [6:0] a, input logic [7:0] w,
                          input int pulse_at, input bit poke_done, output int lat);
        @(negedge clk);
        bus.start = 1'b1;
        bus.rw    = r;
        bus.addr  = a;
        bus.wdata = w;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        lat = -1;
        for (int c = 1; c <= LAT + 200; c++) begin
            @(posedge clk);
            #1;
            if (pulse_at == c) begin
                bus.start = 1'b1;
                bus.rw    = 1'b1;
                bus.addr  = 7'h7F;
                bus.wdata = 8'hFF;
            end else if (pulse_at + 1 == c) begin
                bus.start = 1'b0;
            end
            if (bus.done === 1'b1) begin
                lat = c;
                if (poke_done) bus.start = 1'b1;
                @(posedge clk);
                #1;
                if (poke_done) check("busy_after_start_in_done_cycle", 32'(bus.busy), 32'd0);
                bus.start = 1'b0;
                break;
            end
        end
        bus.start = 1'b0;
    endtask

    typedef struct {
        logic       rw;
        logic [6:0] addr;
        logic [7:0] wdata;
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] rd;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int lat;
        int nd;

        vecs[0] = '{1'b0, 7'h05, 8'hA5, 8'h0A, 8'hA5, 8'h00};
        vecs[1] = '{1'b0, 7'h12, 8'h3C, 8'h24, 8'h3C, 8'h00};
        vecs[2] = '{1'b1, 7'h12, 8'h99, 8'h25, 8'h00, 8'h3C};
        vecs[3] = '{1'b0, 7'h2A, 8'hC3, 8'h54, 8'hC3, 8'h3C};
        vecs[4] = '{1'b1, 7'h2A, 8'h00, 8'h55, 8'h00, 8'hC3};
        vecs[5] = '{1'b1, 7'h05, 8'h00, 8'h0B, 8'h00, 8'hA5};

        reset     = 1'b1;
        bus.start = 1'b0;
        bus.rw    = 1'b0;
        bus.addr  = 7'h00;
        bus.wdata = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("reset_cs",    32'(bus.cs),    32'd1);
        check("reset_sclk",  32'(bus.sclk),  32'd0);
        check("reset_mosi",  32'(bus.mosi),  32'd0);
        check("reset_busy",  32'(bus.busy),  32'd0);
        check("reset_done",  32'(bus.done),  32'd0);
        check("reset_rdata", 32'(bus.rdata), 32'h00);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 6; i++) begin
            do_txn(vecs[i].rw, vecs[i].addr, vecs[i].wdata, 0, 1'b0, lat);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(LAT));
            check($sformatf("vec%0d_rises", i), 32'(rises), 32'd16);
            check($sformatf("vec%0d_byte0", i), 32'(cap[15:8]), 32'(vecs[i].b0));
            check($sformatf("vec%0d_byte1", i), 32'(cap[7:0]), 32'(vecs[i].b1));
            check($sformatf("vec%0d_rdata", i), 32'(bus.rdata), 32'(vecs[i].rd));
        end

        // Start pulsed mid-frame is dropped, and so is a start in the done cycle.
        do_txn(1'b0, 7'h2B, 8'h5E, 100, 1'b1, lat);
        check("midstart_latency", 32'(lat), 32'(LAT));
        check("midstart_byte0", 32'(cap[15:8]), 32'h56);
        check("midstart_byte1", 32'(cap[7:0]), 32'h5E);
        nd = 0;
        repeat (LAT + 50) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) nd++;
        end
        check("midstart_extra_done", 32'(nd), 32'd0);

        // Back-to-back writes: second start in the cycle after done.
        do_txn(1'b0, 7'h2C, 8'h81, 0, 1'b0, lat);
        check("b2b_first_latency", 32'(lat), 32'(LAT));
        check("b2b_first_byte0", 32'(cap[15:8]), 32'h58);
        do_txn(1'b0, 7'h2D, 8'h7E, 0, 1'b0, lat);
        check("b2b_second_latency", 32'(lat), 32'(LAT));
        check("b2b_gap_min", 32'(last_gap >= GP), 32'd1);
        check("b2b_second_byte0", 32'(cap[15:8]), 32'h5A);
        check("b2b_second_byte1", 32'(cap[7:0]), 32'h7E);
        do_txn(1'b1, 7'h2C, 8'h00, 0, 1'b0, lat);
        check("b2b_readback_2c", 32'(bus.rdata), 32'h81);
        do_txn(1'b1, 7'h2B, 8'h00, 0, 1'b0, lat);
        check("readback_2b", 32'(bus.rdata), 32'h5E);

        check("sclk_high_width_errors", 32'(bad_hi), 32'd0);

        // Reset three cycles mid-frame; start held with the last reset cycle.
        @(negedge clk);
        bus.start = 1'b1;
        bus.rw    = 1'b1;
        bus.addr  = 7'h2D;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (199) @(posedge clk);
        #1;
        check("pre_reset_cs_low", 32'(bus.cs), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("midreset_cs",    32'(bus.cs),    32'd1);
        check("midreset_sclk",  32'(bus.sclk),  32'd0);
        check("midreset_mosi",  32'(bus.mosi),  32'd0);
        check("midreset_busy",  32'(bus.busy),  32'd0);
        check("midreset_done",  32'(bus.done),  32'd0);
        check("midreset_rdata", 32'(bus.rdata), 32'h00);
        @(negedge clk);
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        reset     = 1'b0;
        bus.start = 1'b0;
        nd = 0;
        repeat (LAT + 50) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1 || bus.busy === 1'b1) nd++;
        end
        check("after_reset_request_dropped", 32'(nd), 32'd0);

        do_txn(1'b1, 7'h2D, 8'h00, 0, 1'b0, lat);
        check("recover_latency", 32'(lat), 32'(LAT));
        check("recover_rdata", 32'(bus.rdata), 32'h7E);
        check("sclk_while_cs_high", 32'(bad_idle), 32'd0);
        check("mosi_change_while_sclk_high", 32'(bad_mosi), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
